method_test_sequencer: RTL

- Synthesisable successor to per-design simulation tops: drives the req/busy/return handshake of up to NUM_TESTS generated test methods in sequence.
- Applies per-test cycle timeouts and collects per-test pass/fail/timeout results.
- Raises a single done/pass summary for a bench or on-chip status register.
- Sits between a bench or CPU register block and the instantiated generated design's test_req/test_busy/test_return ports.

---
 rtl/method_test_sequencer_if.sv | 32 +++
 rtl/method_test_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/method_test_sequencer_if.sv
// ----------------------------------------------------------------------------
// method_test_sequencer_if
// Request/busy/return handshake bundle between the test sequencer and the
// generated design's test-method ports. There is one channel per test method.
//
//   test_req    : one-hot method request from the sequencer
//   test_busy   : method busy from the generated design
//   test_return : method boolean return, valid once busy falls after a run
//
// Modports:
//   master - the sequencer side (drives test_req)
//   slave  - the generated-design side (drives test_busy / test_return)
// ----------------------------------------------------------------------------
interface method_test_sequencer_if #(
  parameter int NUM_TESTS = 4
);
  logic [NUM_TESTS-1:0] test_req;
  logic [NUM_TESTS-1:0] test_busy;
  logic [NUM_TESTS-1:0] test_return;

  modport master (
    output test_req,
    input  test_busy,
    input  test_return
  );

  modport slave (
    input  test_req,
    output test_busy,
    output test_return
  );
endinterface

// File: rtl/method_test_sequencer.sv
// ----------------------------------------------------------------------------
// method_test_sequencer
// Runs up to NUM_TESTS generated test methods one after another through their
// req/busy/return handshake. A per-test cycle timeout is applied, and
// pass/fail/timeout results are collected into a single done/pass summary.
//
// Ports:
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   start        : starts a sequence; only sampled while idle
//   enable_mask  : tests to run, captured at start
//   tif          : handshake to the generated design (master side)
//   busy         : sequence in progress
//   done         : sequence complete, held until the next start
//   pass         : valid with done; all enabled tests returned 1, none timed out
//   fail_mask    : bit i set when test i returned 0
//   timeout_mask : bit i set when test i timed out
//   cur_test     : index of the test in progress
// ----------------------------------------------------------------------------
module method_test_sequencer #(
  parameter int NUM_TESTS    = 4,
  parameter int TIMEOUT_W    = 28,
  parameter int TIMEOUT      = 200000000,
  parameter int SETTLE       = 4,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_TESTS-1:0]     enable_mask,
  method_test_sequencer_if.master  tif,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [NUM_TESTS-1:0]     fail_mask,
  output logic [NUM_TESTS-1:0]     timeout_mask,
  output logic [3:0]               cur_test
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SCAN      = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_SETTLE    = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  localparam int IDX_W    = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_TESTS - 1);
  // The settle state always lasts at least one cycle, so SETTLE=0 and
  // SETTLE=1 behave the same.
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST = (SETTLE > 0) ? SETTLE_W'(SETTLE - 1) : '0;
  // A test times out in the wait cycle whose increment would bring the
  // counter to TIMEOUT, so exactly TIMEOUT wait cycles are allowed.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST    = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX     = TIMEOUT_W'(TIMEOUT);

  logic [2:0]           state;
  logic [NUM_TESTS-1:0] en_q;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [SETTLE_W-1:0]  settle_cnt;

  logic [IDX_W-1:0]     idx;
  logic [NUM_TESTS-1:0] cur_onehot;
  logic                 cur_en;
  logic                 cur_busy;
  logic                 cur_ret;
  logic                 last_idx;
  logic                 any_bad;

  assign idx        = cur_test[IDX_W-1:0];
  assign cur_onehot = NUM_TESTS'(1) << idx;
  assign cur_en     = en_q[idx];
  assign cur_busy   = tif.test_busy[idx];
  assign cur_ret    = tif.test_return[idx];
  assign last_idx   = (idx == IDX_LAST);
  assign any_bad    = |(fail_mask | timeout_mask);

  // NOTE: test_req is decoded straight from the state register with a full
  // ternary (no incomplete if), so no latch is possible and it drops the
  // instant reset clears the state, without waiting for a clock edge.
  assign tif.test_req = ((state == S_ISSUE) || (state == S_WAIT_ACK)) ? cur_onehot : '0;

  // NOTE: every register, including the counters and the captured mask, is
  // cleared by the asynchronous reset; there is no memory array here, so
  // nothing is left to power up unknown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      en_q         <= '0;
      tmo_cnt      <= '0;
      settle_cnt   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_mask    <= '0;
      timeout_mask <= '0;
      cur_test     <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so each
      // branch below reads the values from before this clock edge.
      case (state)
        S_IDLE: begin
          if (start) begin
            en_q         <= enable_mask;
            fail_mask    <= '0;
            timeout_mask <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            cur_test     <= '0;
            state        <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (cur_en) begin
            state <= S_ISSUE;
          end else if (last_idx) begin
            state <= S_FINISH;
          end else begin
            cur_test <= cur_test + 4'd1;
          end
        end

        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT_ACK;
        end

        S_WAIT_ACK, S_WAIT_DONE: begin
          if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          // Completion is checked before the timeout, so a busy fall in
          // the last allowed cycle still counts as a real result.
          if ((state == S_WAIT_DONE) && !cur_busy) begin
            if (!cur_ret) begin
              fail_mask[idx] <= 1'b1;
            end
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_mask[idx] <= 1'b1;
            settle_cnt        <= '0;
            state             <= S_SETTLE;
          end else if ((state == S_WAIT_ACK) && cur_busy) begin
            state <= S_WAIT_DONE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            if ((STOP_ON_FAIL && any_bad) || last_idx) begin
              state <= S_FINISH;
            end else begin
              cur_test <= cur_test + 4'd1;
              state    <= S_SCAN;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= ~any_bad;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
